// File: rtl/mips_pipeline.sv
// Five-stage in-order MIPS32 core covering the logic and shift subset.
// Instructions come from an external combinational ROM. There is no data
// memory, so the MEM stage only passes results through. Operands are
// forwarded from EX and MEM into ID, so no stall logic is needed.

// General-purpose register file: two combinational read ports and one
// synchronous write port. Register 0 is hard-wired to zero. A read of the
// register being written in the same cycle returns the new value.
module gpr_file (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2
);

  logic [31:0] regs [0:31];

  // Register storage. Writes to $0 are dropped, so regs[0] stays zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read port 1. A same-cycle write is bypassed so that WB needs no forward path.
  always_comb begin
    rdata1 = regs[raddr1];
    if (raddr1 == 5'd0)                  rdata1 = 32'h0;
    else if (we && (waddr == raddr1))    rdata1 = wdata;
  end

  // Read port 2. It uses the same write-through rule as port 1.
  always_comb begin
    rdata2 = regs[raddr2];
    if (raddr2 == 5'd0)                  rdata2 = 32'h0;
    else if (we && (waddr == raddr2))    rdata2 = wdata;
  end

endmodule

module mips_pipeline (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] rom_data,
  output logic [31:0] rom_addr,
  output logic        rom_chip_enable
);

  typedef enum logic [2:0] {
    ALU_NOP, ALU_OR, ALU_AND, ALU_XOR, ALU_NOR, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_t;

  logic [31:0] pc;
  logic        chip_enable;

  logic [31:0] if_id_inst;

  alu_op_t     id_alu_op;
  logic        id_we;
  logic [4:0]  id_wreg;
  logic [31:0] id_op_a;
  logic [31:0] id_op_b;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;

  alu_op_t     id_ex_alu_op;
  logic        id_ex_we;
  logic [4:0]  id_ex_wreg;
  logic [31:0] id_ex_a;
  logic [31:0] id_ex_b;
  logic [31:0] ex_result;

  logic        ex_mem_we;
  logic [4:0]  ex_mem_wreg;
  logic [31:0] ex_mem_wdata;

  logic        mem_wb_we;
  logic [4:0]  mem_wb_wreg;
  logic [31:0] mem_wb_wdata;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign rom_addr        = pc;
  assign rom_chip_enable = chip_enable;

  // Fetch control. The chip enable rises one edge after reset. The PC starts
  // advancing only on the edge after that, so address 0 is fetched first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chip_enable <= 1'b0;
      pc          <= 32'h0;
    end else begin
      chip_enable <= 1'b1;
      if (!chip_enable) pc <= 32'h0;
      else              pc <= pc + 32'd4;
    end
  end

  // IF/ID register. While the ROM is disabled it returns 0, which decodes as a harmless NOP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) if_id_inst <= 32'h0;
    else        if_id_inst <= rom_data;
  end

  assign opcode = if_id_inst[31:26];
  assign rs     = if_id_inst[25:21];
  assign rt     = if_id_inst[20:16];
  assign rd     = if_id_inst[15:11];
  assign sa     = if_id_inst[10:6];
  assign funct  = if_id_inst[5:0];
  assign imm    = if_id_inst[15:0];

  gpr_file gpr_file_instance (
    .clock  (clock),
    .reset  (reset),
    .we     (mem_wb_we),
    .waddr  (mem_wb_wreg),
    .wdata  (mem_wb_wdata),
    .raddr1 (rs),
    .rdata1 (rf_rdata1),
    .raddr2 (rt),
    .rdata2 (rf_rdata2)
  );

  // Operand forwarding. The youngest producer (EX) wins over MEM, and MEM
  // wins over the register file, which already bypasses WB.
  always_comb begin
    rs_val = rf_rdata1;
    rt_val = rf_rdata2;
    if (id_ex_we && (id_ex_wreg == rs) && (rs != 5'd0))          rs_val = ex_result;
    else if (ex_mem_we && (ex_mem_wreg == rs) && (rs != 5'd0))   rs_val = ex_mem_wdata;
    if (id_ex_we && (id_ex_wreg == rt) && (rt != 5'd0))          rt_val = ex_result;
    else if (ex_mem_we && (ex_mem_wreg == rt) && (rt != 5'd0))   rt_val = ex_mem_wdata;
  end

  // Decode. Operand A is the shift amount for shifts and 0 for LUI, so every
  // instruction reduces to a single ALU operation on A and B.
  always_comb begin
    id_alu_op = ALU_NOP;
    id_we     = 1'b0;
    id_wreg   = 5'd0;
    id_op_a   = 32'h0;
    id_op_b   = 32'h0;
    case (opcode)
      6'h0D: begin id_alu_op = ALU_OR;  id_we = 1'b1; id_wreg = rt; id_op_a = rs_val; id_op_b = {16'h0, imm}; end
      6'h0C: begin id_alu_op = ALU_AND; id_we = 1'b1; id_wreg = rt; id_op_a = rs_val; id_op_b = {16'h0, imm}; end
      6'h0E: begin id_alu_op = ALU_XOR; id_we = 1'b1; id_wreg = rt; id_op_a = rs_val; id_op_b = {16'h0, imm}; end
      6'h0F: begin id_alu_op = ALU_OR;  id_we = 1'b1; id_wreg = rt; id_op_a = 32'h0;  id_op_b = {imm, 16'h0}; end
      6'h00: begin
        id_wreg = rd;
        id_op_b = rt_val;
        case (funct)
          6'h24: begin id_alu_op = ALU_AND; id_we = 1'b1; id_op_a = rs_val; end
          6'h25: begin id_alu_op = ALU_OR;  id_we = 1'b1; id_op_a = rs_val; end
          6'h26: begin id_alu_op = ALU_XOR; id_we = 1'b1; id_op_a = rs_val; end
          6'h27: begin id_alu_op = ALU_NOR; id_we = 1'b1; id_op_a = rs_val; end
          6'h00: begin id_alu_op = ALU_SLL; id_we = 1'b1; id_op_a = {27'h0, sa}; end
          6'h02: begin id_alu_op = ALU_SRL; id_we = 1'b1; id_op_a = {27'h0, sa}; end
          6'h03: begin id_alu_op = ALU_SRA; id_we = 1'b1; id_op_a = {27'h0, sa}; end
          6'h04: begin id_alu_op = ALU_SLL; id_we = 1'b1; id_op_a = rs_val; end
          6'h06: begin id_alu_op = ALU_SRL; id_we = 1'b1; id_op_a = rs_val; end
          6'h07: begin id_alu_op = ALU_SRA; id_we = 1'b1; id_op_a = rs_val; end
          default: begin id_wreg = 5'd0; id_op_b = 32'h0; end
        endcase
      end
      default: ;
    endcase
  end

  // ID/EX register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      id_ex_alu_op <= ALU_NOP;
      id_ex_we     <= 1'b0;
      id_ex_wreg   <= 5'd0;
      id_ex_a      <= 32'h0;
      id_ex_b      <= 32'h0;
    end else begin
      id_ex_alu_op <= id_alu_op;
      id_ex_we     <= id_we;
      id_ex_wreg   <= id_wreg;
      id_ex_a      <= id_op_a;
      id_ex_b      <= id_op_b;
    end
  end

  // ALU. Shifts move operand B by the low five bits of operand A.
  always_comb begin
    ex_result = 32'h0;
    case (id_ex_alu_op)
      ALU_OR:  ex_result = id_ex_a | id_ex_b;
      ALU_AND: ex_result = id_ex_a & id_ex_b;
      ALU_XOR: ex_result = id_ex_a ^ id_ex_b;
      ALU_NOR: ex_result = ~(id_ex_a | id_ex_b);
      ALU_SLL: ex_result = id_ex_b << id_ex_a[4:0];
      ALU_SRL: ex_result = id_ex_b >> id_ex_a[4:0];
      ALU_SRA: ex_result = $unsigned($signed(id_ex_b) >>> id_ex_a[4:0]);
      default: ex_result = 32'h0;
    endcase
  end

  // EX/MEM register. The MEM stage is a plain pass-through of these fields.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_mem_we    <= 1'b0;
      ex_mem_wreg  <= 5'd0;
      ex_mem_wdata <= 32'h0;
    end else begin
      ex_mem_we    <= id_ex_we;
      ex_mem_wreg  <= id_ex_wreg;
      ex_mem_wdata <= ex_result;
    end
  end

  // MEM/WB register. It feeds the register file write port.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_wb_we    <= 1'b0;
      mem_wb_wreg  <= 5'd0;
      mem_wb_wdata <= 32'h0;
    end else begin
      mem_wb_we    <= ex_mem_we;
      mem_wb_wreg  <= ex_mem_wreg;
      mem_wb_wdata <= ex_mem_wdata;
    end
  end

endmodule

// File: tb/tb_mips_pipeline.sv
// Testbench for mips_pipeline. A small ROM model holds each program. An
// instruction-level interpreter predicts when each register write lands and
// what value it carries.
module tb_mips_pipeline;

  logic        clock;
  logic        reset;
  logic [31:0] rom_data;
  logic [31:0] rom_addr;
  logic        rom_chip_enable;

  logic [31:0] rom_mem   [0:63];
  logic [31:0] model_regs [0:31];
  int vectors;
  int miscompares;

  mips_pipeline dut (
    .clock           (clock),
    .reset           (reset),
    .rom_data        (rom_data),
    .rom_addr        (rom_addr),
    .rom_chip_enable (rom_chip_enable)
  );

  // Free-running clock with a 10-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM model. It returns 0 when disabled or outside the programmed window.
  assign rom_data = (!rom_chip_enable)        ? 32'h0 :
                    (rom_addr < 32'd256)      ? rom_mem[rom_addr[7:2]] : 32'h0;

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom_mem[i] = 32'h0;
  endtask

  // Architectural interpreter: executes one instruction on model_regs.
  task automatic model_exec(input logic [31:0] ins);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  s, t, d, sh;
    logic [31:0] a, b, res;
    logic        wr;
    logic [4:0]  dst;
    op = ins[31:26]; s = ins[25:21]; t = ins[20:16]; d = ins[15:11];
    sh = ins[10:6];  fn = ins[5:0];
    a = model_regs[s]; b = model_regs[t];
    wr = 1'b1; dst = t; res = 32'h0;
    if      (op == 6'h0D) res = a | {16'h0, ins[15:0]};
    else if (op == 6'h0C) res = a & {16'h0, ins[15:0]};
    else if (op == 6'h0E) res = a ^ {16'h0, ins[15:0]};
    else if (op == 6'h0F) res = {ins[15:0], 16'h0};
    else if (op == 6'h00) begin
      dst = d;
      if      (fn == 6'h24) res = a & b;
      else if (fn == 6'h25) res = a | b;
      else if (fn == 6'h26) res = a ^ b;
      else if (fn == 6'h27) res = ~(a | b);
      else if (fn == 6'h00) res = b << sh;
      else if (fn == 6'h02) res = b >> sh;
      else if (fn == 6'h03) res = $unsigned($signed(b) >>> sh);
      else if (fn == 6'h04) res = b << a[4:0];
      else if (fn == 6'h06) res = b >> a[4:0];
      else if (fn == 6'h07) res = $unsigned($signed(b) >>> a[4:0]);
      else wr = 1'b0;
    end else wr = 1'b0;
    if (wr && dst != 5'd0) model_regs[dst] = res;
  endtask

  // Assert reset without waiting for a clock. Everything must clear at once
  // and stay clear for three cycles. Release happens on a falling edge, so
  // the next rising edge is E1.
  task automatic apply_reset();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    check("reset_ce_now", {31'h0, rom_chip_enable}, 32'h0);
    check("reset_addr_now", rom_addr, 32'h0);
    for (int i = 0; i < 32; i++)
      check($sformatf("reset_regs[%0d]", i), dut.gpr_file_instance.regs[i], 32'h0);
    repeat (3) @(posedge clock);
    #1;
    check("reset_ce_held", {31'h0, rom_chip_enable}, 32'h0);
    check("reset_addr_held", rom_addr, 32'h0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Step the core through the program. The fetch address is checked on every
  // edge. The whole register file is compared against the interpreter on
  // each edge where an instruction retires. A nonzero stop_edge ends the run early.
  task automatic apply_stimulus(input int n, input int stop_edge);
    int total;
    total = (stop_edge != 0) ? stop_edge : (6 + n + 1);
    for (int e = 1; e <= total; e++) begin
      @(posedge clock);
      #1;
      check($sformatf("ce@E%0d", e), {31'h0, rom_chip_enable}, 32'h1);
      check($sformatf("rom_addr@E%0d", e), rom_addr, 32'(4 * (e - 1)));
      if (e >= 6 && (e - 6) < n) begin
        model_exec(rom_mem[e - 6]);
        for (int r = 0; r < 32; r++)
          check($sformatf("regs[%0d]@E%0d", r, e), dut.gpr_file_instance.regs[r], model_regs[r]);
      end
    end
  endtask

  task automatic check_output(input string tag, input int r, input logic [31:0] expected);
    check(tag, dut.gpr_file_instance.regs[r], expected);
  endtask

  task automatic load_scenario2();
    clear_rom();
    rom_mem[0] = i_type(6'h0D, 5'd0, 5'd1, 16'h1100);
    rom_mem[1] = i_type(6'h0D, 5'd1, 5'd2, 16'h0020);
    rom_mem[2] = i_type(6'h0D, 5'd2, 5'd3, 16'h4400);
    rom_mem[3] = i_type(6'h0D, 5'd1, 5'd4, 16'h0044);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    clear_rom();
    #2;

    $display("[TB] reset, fetch start and back-to-back dependence");
    load_scenario2();
    apply_reset();
    apply_stimulus(4, 0);
    check_output("s2_r1", 1, 32'h00001100);
    check_output("s2_r2", 2, 32'h00001120);
    check_output("s2_r3", 3, 32'h00005520);
    check_output("s2_r4", 4, 32'h00001144);

    $display("[TB] reset mid-run and restart");
    apply_reset();
    apply_stimulus(4, 7);
    check_output("s6_r1_pre", 1, 32'h00001100);
    check_output("s6_r2_pre", 2, 32'h00001120);
    apply_reset();
    apply_stimulus(4, 0);
    check_output("s6_r3", 3, 32'h00005520);
    check_output("s6_r4", 4, 32'h00001144);

    $display("[TB] logic ops");
    clear_rom();
    rom_mem[0] = i_type(6'h0F, 5'd0, 5'd1, 16'h0101);
    rom_mem[1] = i_type(6'h0D, 5'd1, 5'd1, 16'h0101);
    rom_mem[2] = r_type(5'd1, 5'd1, 5'd2, 5'd0, 6'h25);
    rom_mem[3] = i_type(6'h0C, 5'd1, 5'd3, 16'h00FE);
    rom_mem[4] = i_type(6'h0E, 5'd1, 5'd4, 16'hFF00);
    rom_mem[5] = r_type(5'd1, 5'd0, 5'd5, 5'd0, 6'h27);
    apply_reset();
    apply_stimulus(6, 0);
    check_output("s3_r1", 1, 32'h01010101);
    check_output("s3_r2", 2, 32'h01010101);
    check_output("s3_r3", 3, 32'h00000000);
    check_output("s3_r4", 4, 32'h0101FE01);
    check_output("s3_r5", 5, 32'hFEFEFEFE);

    $display("[TB] shifts");
    clear_rom();
    rom_mem[0] = i_type(6'h0F, 5'd0, 5'd2, 16'h8000);
    rom_mem[1] = r_type(5'd0, 5'd2, 5'd3, 5'd4, 6'h03);
    rom_mem[2] = r_type(5'd0, 5'd2, 5'd4, 5'd4, 6'h02);
    rom_mem[3] = i_type(6'h0D, 5'd0, 5'd5, 16'h0008);
    rom_mem[4] = r_type(5'd5, 5'd5, 5'd6, 5'd0, 6'h04);
    apply_reset();
    apply_stimulus(5, 0);
    check_output("s4_r3", 3, 32'hF8000000);
    check_output("s4_r4", 4, 32'h08000000);
    check_output("s4_r6", 6, 32'h00000800);

    $display("[TB] $0 and NOP");
    clear_rom();
    rom_mem[0] = i_type(6'h0D, 5'd0, 5'd0, 16'hFFFF);
    rom_mem[1] = 32'hFC000000;
    rom_mem[2] = r_type(5'd0, 5'd0, 5'd1, 5'd0, 6'h25);
    apply_reset();
    apply_stimulus(3, 0);
    check_output("s5_r0", 0, 32'h0);
    check_output("s5_r1", 1, 32'h0);

    $display("[TB] randomized programs");
    for (int p = 0; p < 6; p++) begin
      clear_rom();
      for (int i = 0; i < 24; i++) begin
        logic [4:0]  s, t, d, sh;
        logic [15:0] im;
        s  = 5'($urandom_range(0, 7));
        t  = 5'($urandom_range(0, 7));
        d  = 5'($urandom_range(0, 7));
        sh = 5'($urandom);
        im = 16'($urandom);
        case ($urandom_range(0, 14))
          0:  rom_mem[i] = i_type(6'h0D, s, t, im);
          1:  rom_mem[i] = i_type(6'h0C, s, t, im);
          2:  rom_mem[i] = i_type(6'h0E, s, t, im);
          3:  rom_mem[i] = i_type(6'h0F, s, t, im);
          4:  rom_mem[i] = r_type(s, t, d, 5'd0, 6'h24);
          5:  rom_mem[i] = r_type(s, t, d, 5'd0, 6'h25);
          6:  rom_mem[i] = r_type(s, t, d, 5'd0, 6'h26);
          7:  rom_mem[i] = r_type(s, t, d, 5'd0, 6'h27);
          8:  rom_mem[i] = r_type(5'd0, t, d, sh, 6'h00);
          9:  rom_mem[i] = r_type(5'd0, t, d, sh, 6'h02);
          10: rom_mem[i] = r_type(5'd0, t, d, sh, 6'h03);
          11: rom_mem[i] = r_type(s, t, d, 5'd0, 6'h04);
          12: rom_mem[i] = r_type(s, t, d, 5'd0, 6'h06);
          13: rom_mem[i] = r_type(s, t, d, 5'd0, 6'h07);
          default: rom_mem[i] = ($urandom_range(0, 1) == 0) ? {6'h3F, 26'($urandom)}
                                                             : r_type(s, t, d, sh, 6'h01);
        endcase
      end
      apply_reset();
      apply_stimulus(24, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
